// File: rtl/bus_pkg.sv
// Shared field widths and the serial frame layout for the frame receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

    parameter int CMD_WIDTH  = 2;
    parameter int ADDR_WIDTH = 16;
    parameter int DATA_WIDTH = 8;
    // start + cmd + addr + data + parity + stop
    parameter int FRAME_BITS = 1 + CMD_WIDTH + ADDR_WIDTH + DATA_WIDTH + 1 + 1;

    // Field order matches wire order, so the first bit received lands in the MSB.
    typedef struct packed {
        logic                  start;
        logic [CMD_WIDTH-1:0]  cmd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  parity;
        logic                  stop;
    } serial_frame_t;

endpackage

// File: rtl/frame_receiver.sv
// Assembles strobed serial bits (start, cmd, addr, data, parity, stop; MSB first) into a frame.
// Latency: frame_valid_o pulses 1 cycle after the stop-bit strobe.
// Backpressure: none; strobes in DONE are dropped, stalls longer than TIMEOUT_CYCLES abort.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   bit_valid_i, bit_i    one-cycle bit strobe and the sampled line bit
//   frame_valid_o         one-cycle pulse when frame_o/parity_err_o carry a new frame
//   frame_o               last complete frame, held until the next one
//   parity_err_o          even-parity check failed for frame_o
//   timeout_o             one-cycle pulse when a partial frame is aborted
//   busy_o                frame reception in progress
module frame_receiver
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          bit_valid_i,
    input  logic          bit_i,
    output logic          frame_valid_o,
    output serial_frame_t frame_o,
    output logic          parity_err_o,
    output logic          timeout_o,
    output logic          busy_o
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q;
    logic [FRAME_BITS-1:0]   shift_q;
    logic [FRAME_BITS-1:0]   shift_d;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [TO_W-1:0]         to_cnt_q;
    serial_frame_t           frame_q;
    serial_frame_t           frame_d;
    logic                    frame_valid_q;
    logic                    parity_err_q;
    logic                    parity_err_d;
    logic                    timeout_q;
    logic                    last_bit;
    logic                    to_expire;

    // Shift left so the earliest bit (start) ends up in the frame MSB.
    assign shift_d      = {shift_q[FRAME_BITS-2:0], bit_i};
    assign frame_d      = serial_frame_t'(shift_d);
    assign parity_err_d = ^{frame_d.cmd, frame_d.addr, frame_d.data, frame_d.parity};

    // bit_cnt_q counts bits already held; the strobe at FRAME_BITS-1 delivers the stop bit.
    assign last_bit  = (bit_cnt_q == CNT_W'(FRAME_BITS - 1));
    assign to_expire = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            to_cnt_q      <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            parity_err_q  <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // A zero strobe is just the idle line level.
                    if (bit_valid_i && bit_i) begin
                        shift_q   <= FRAME_BITS'(1);
                        bit_cnt_q <= CNT_W'(1);
                        to_cnt_q  <= '0;
                        state_q   <= S_RECV;
                    end
                end
                S_RECV: begin
                    // A strobe wins over an expiring timeout in the same cycle.
                    if (bit_valid_i) begin
                        to_cnt_q <= '0;
                        if (last_bit) begin
                            frame_q       <= frame_d;
                            parity_err_q  <= parity_err_d;
                            frame_valid_q <= 1'b1;
                            shift_q       <= '0;
                            bit_cnt_q     <= '0;
                            state_q       <= S_DONE;
                        end else begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        end
                    end else if (to_expire) begin
                        timeout_q <= 1'b1;
                        shift_q   <= '0;
                        bit_cnt_q <= '0;
                        to_cnt_q  <= '0;
                        state_q   <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                S_DONE: begin
                    // Strobes here are dropped; this cycle is the inter-frame gap.
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign frame_valid_o = frame_valid_q;
    assign frame_o       = frame_q;
    assign parity_err_o  = parity_err_q;
    assign timeout_o     = timeout_q;
    assign busy_o        = (state_q == S_RECV);

endmodule

// File: tb/tb_frame_receiver.sv
// Directed bench for frame_receiver: table of frames plus reset, timeout and back-to-back sequences.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_frame_receiver;
    import bus_pkg::*;

    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          bit_valid_i;
    logic          bit_i;
    logic          frame_valid_o;
    serial_frame_t frame_o;
    logic          parity_err_o;
    logic          timeout_o;
    logic          busy_o;

    frame_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .bit_valid_i  (bit_valid_i),
        .bit_i        (bit_i),
        .frame_valid_o(frame_valid_o),
        .frame_o      (frame_o),
        .parity_err_o (parity_err_o),
        .timeout_o    (timeout_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int frames_seen = 0;
    int to_seen     = 0;
    logic [28:0] rx_q[$];
    logic        rx_perr_q[$];

    // Record every output pulse on the falling edge.
    always @(negedge clk) begin
        if (frame_valid_o) begin
            frames_seen++;
            rx_q.push_back(frame_o);
            rx_perr_q.push_back(parity_err_o);
        end
        if (timeout_o) to_seen++;
    end

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        par;
        logic        stop;
        logic        exp_perr;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v, input int gap);
        bit_valid_i = 1'b1;
        bit_i       = v;
        tick();
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        repeat (gap) tick();
    endtask

    function automatic logic [28:0] mk(input logic [1:0] cmd, input logic [15:0] addr,
                                       input logic [7:0] data, input logic par, input logic stop);
        return {1'b1, cmd, addr, data, par, stop};
    endfunction

    // Send wire bits first..last of f (bit 0 = start); no gap after the stop bit.
    task automatic send_bits(input logic [28:0] f, input int first, input int last,
                             input int gap, input bit rnd);
        for (int i = first; i <= last; i++) begin
            int g;
            g = (i == 28) ? 0 : (rnd ? int'($urandom_range(0, 5)) : gap);
            send_bit(f[28-i], g);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [28:0] f, input logic perr);
        chk({tag, ".valid"}, 32'(frame_valid_o), 32'd1);
        chk({tag, ".frame"}, 32'(frame_o), 32'(f));
        chk({tag, ".perr"},  32'(parity_err_o), 32'(perr));
    endtask

    initial begin
        logic [28:0] f;
        logic [28:0] exp_q[$];
        logic        exp_perr_q[$];
        int t0;
        int fs0;

        vt[0] = '{2'b01, 16'h1234, 8'hA5, 1'b0, 1'b1, 1'b0};
        vt[1] = '{2'b01, 16'h1234, 8'hA5, 1'b1, 1'b1, 1'b1};
        vt[2] = '{2'b01, 16'h1234, 8'hA5, 1'b0, 1'b0, 1'b0};
        vt[3] = '{2'b11, 16'hFFFF, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[4] = '{2'b10, 16'h0001, 8'h80, 1'b1, 1'b1, 1'b0};
        vt[5] = '{2'b00, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1};
        vt[6] = '{2'b00, 16'h0000, 8'h01, 1'b0, 1'b1, 1'b1};

        // Reset with a start strobe held: must be ignored.
        rst_i       = 1'b1;
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        repeat (3) tick();
        chk("rst.valid", 32'(frame_valid_o), 32'd0);
        chk("rst.frame", 32'(frame_o), 32'd0);
        chk("rst.perr",  32'(parity_err_o), 32'd0);
        chk("rst.tout",  32'(timeout_o), 32'd0);
        chk("rst.busy",  32'(busy_o), 32'd0);

        // Strobe in the first cycle after release is a real start bit.
        rst_i = 1'b0;
        tick();
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        chk("rel.busy", 32'(busy_o), 32'd1);
        f = mk(vt[0].cmd, vt[0].addr, vt[0].data, vt[0].par, vt[0].stop);
        tick();
        send_bits(f, 1, 28, 0, 1'b0);
        chk_frame("rel", f, 1'b0);
        tick();

        // Table of frames with one idle cycle between strobes.
        for (int k = 0; k < 7; k++) begin
            string tag;
            tag = $sformatf("vec%0d", k);
            f = mk(vt[k].cmd, vt[k].addr, vt[k].data, vt[k].par, vt[k].stop);
            send_bits(f, 0, 0, 1, 1'b0);
            chk({tag, ".busy"}, 32'(busy_o), 32'd1);
            send_bits(f, 1, 28, 1, 1'b0);
            chk_frame(tag, f, vt[k].exp_perr);
            chk({tag, ".busy_done"}, 32'(busy_o), 32'd0);
            tick();
            chk({tag, ".pulse_end"}, 32'(frame_valid_o), 32'd0);
            chk({tag, ".hold"}, 32'(frame_o), 32'(f));
        end

        // Start strobe during DONE must be dropped.
        t0 = to_seen;
        f = mk(vt[3].cmd, vt[3].addr, vt[3].data, vt[3].par, vt[3].stop);
        send_bits(f, 0, 28, 0, 1'b0);
        chk_frame("done_drop", f, 1'b0);
        bit_valid_i = 1'b1;
        bit_i       = 1'b1;
        tick();
        bit_valid_i = 1'b0;
        bit_i       = 1'b0;
        chk("done_drop.busy", 32'(busy_o), 32'd0);
        repeat (TO + 4) tick();
        chk("done_drop.tout", 32'(to_seen - t0), 32'd0);

        // Timeout after 10 bits.
        t0  = to_seen;
        fs0 = frames_seen;
        f = mk(vt[0].cmd, vt[0].addr, vt[0].data, vt[0].par, vt[0].stop);
        send_bits(f, 0, 9, 0, 1'b0);
        repeat (TO - 1) tick();
        chk("tout.early", 32'(timeout_o), 32'd0);
        chk("tout.busy",  32'(busy_o), 32'd1);
        tick();
        chk("tout.pulse", 32'(timeout_o), 32'd1);
        chk("tout.idle",  32'(busy_o), 32'd0);
        tick();
        chk("tout.end",    32'(timeout_o), 32'd0);
        chk("tout.count",  32'(to_seen - t0), 32'd1);
        chk("tout.nofrm",  32'(frames_seen - fs0), 32'd0);
        send_bits(f, 0, 28, 0, 1'b0);
        chk_frame("tout.next", f, 1'b0);
        tick();

        // Strobe arriving exactly as the counter hits its limit is accepted.
        t0 = to_seen;
        f = mk(vt[1].cmd, vt[1].addr, vt[1].data, vt[1].par, vt[1].stop);
        send_bits(f, 0, 9, 0, 1'b0);
        repeat (TO - 1) tick();
        send_bits(f, 10, 28, 0, 1'b0);
        chk_frame("edge", f, 1'b1);
        chk("edge.tout", 32'(to_seen - t0), 32'd0);
        tick();

        // Reset after 20 bits.
        t0  = to_seen;
        fs0 = frames_seen;
        f = mk(vt[4].cmd, vt[4].addr, vt[4].data, vt[4].par, vt[4].stop);
        send_bits(f, 0, 19, 0, 1'b0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mrst.valid", 32'(frame_valid_o), 32'd0);
        chk("mrst.frame", 32'(frame_o), 32'd0);
        chk("mrst.busy",  32'(busy_o), 32'd0);
        repeat (TO + 4) tick();
        chk("mrst.nofrm", 32'(frames_seen - fs0), 32'd0);
        chk("mrst.notout", 32'(to_seen - t0), 32'd0);
        f = mk(vt[3].cmd, vt[3].addr, vt[3].data, vt[3].par, vt[3].stop);
        send_bits(f, 0, 28, 1, 1'b0);
        chk_frame("mrst.next", f, 1'b0);
        tick();

        // Back-to-back frames with random gaps and idle zero strobes.
        rx_q.delete();
        rx_perr_q.delete();
        for (int k = 0; k < 6; k++) begin
            logic [1:0]  c;
            logic [15:0] a;
            logic [7:0]  d;
            logic        p;
            c = 2'($urandom);
            a = 16'($urandom);
            d = 8'($urandom);
            p = 1'($urandom);
            f = mk(c, a, d, p, 1'b1);
            exp_q.push_back(f);
            exp_perr_q.push_back(^{c, a, d, p});
            if (k % 2 == 1) begin
                repeat ($urandom_range(1, 3)) send_bit(1'b0, int'($urandom_range(0, 2)));
            end
            send_bits(f, 0, 28, 0, 1'b1);
            tick();
        end
        repeat (3) tick();
        chk("b2b.count", 32'(rx_q.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < rx_q.size()) begin
                chk($sformatf("b2b%0d.frame", k), 32'(rx_q[k]), 32'(exp_q[k]));
                chk($sformatf("b2b%0d.perr", k),  32'(rx_perr_q[k]), 32'(exp_perr_q[k]));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
